// File: rtl/l2_burst_grant_sequencer_pkg.sv
// Shared L2 configuration and types.
//   L2_NUM_PORTS   : number of requesters sharing the L2 request path
//   L2_BURST_LEN_W : burst length field width (field holds beats-1)
package l2_config_and_types;

  localparam int unsigned L2_NUM_PORTS   = 4;
  localparam int unsigned L2_BURST_LEN_W = 4;
  // A single-port build still needs a 1-bit index to stay a legal vector.
  localparam int unsigned L2_IDX_W = (L2_NUM_PORTS > 1) ? $clog2(L2_NUM_PORTS) : 1;

  typedef logic [L2_IDX_W-1:0] l2_port_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

endpackage

// File: rtl/l2_burst_grant_sequencer_if.sv
// Request/grant/beat bundle between the per-port request queues and the sequencer.
//   req, req_len, out_ready          : requester/downstream -> sequencer
//   out_valid, out_last, grant_v,
//   grant_i, port_ack, busy          : sequencer -> requesters/downstream
interface l2_burst_grant_sequencer_if
  import l2_config_and_types::*;
#(
  parameter int unsigned NUM_PORTS = L2_NUM_PORTS,
  parameter int unsigned LEN_W     = L2_BURST_LEN_W
);
  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS-1:0][LEN_W-1:0] req_len;
  logic                            out_ready;
  logic                            out_valid;
  logic                            out_last;
  logic [NUM_PORTS-1:0]            grant_v;
  logic [IDX_W-1:0]                grant_i;
  logic [NUM_PORTS-1:0]            port_ack;
  logic                            busy;

  modport master (
    output req, req_len, out_ready,
    input  out_valid, out_last, grant_v, grant_i, port_ack, busy
  );

  modport slave (
    input  req, req_len, out_ready,
    output out_valid, out_last, grant_v, grant_i, port_ack, busy
  );

endinterface

// File: rtl/l2_rr_select.sv
// Combinational round-robin pick: first requesting port after last_idx, wrapping.
//   req       : per-port request vector
//   last_idx  : index of the previous winner (search starts just after it)
//   winner    : selected port index (0 when nothing requests)
//   any_valid : at least one port requests
module l2_rr_select #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_idx,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_valid
);

  int unsigned cand;

  // Visit last+1 .. last+NUM_PORTS; the first hit wins, later hits are ignored.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = (32'(last_idx) + k) % NUM_PORTS;
      if (!any_valid && req[IDX_W'(cand)]) begin
        winner    = IDX_W'(cand);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_burst_grant_sequencer.sv
// Locks the L2 request path to one round-robin-selected port for a whole burst
// and counts beats against downstream ready.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of l2_burst_grant_sequencer_if (req/req_len/out_ready in;
//              out_valid/out_last/grant_v/grant_i/port_ack/busy out)
module l2_burst_grant_sequencer
  import l2_config_and_types::*;
#(
  parameter int unsigned NUM_PORTS = L2_NUM_PORTS,
  parameter int unsigned LEN_W     = L2_BURST_LEN_W
) (
  input logic                        clk,
  input logic                        rst,
  l2_burst_grant_sequencer_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  burst_state_t         state_q, state_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     grant_i_q, grant_i_d;
  logic [NUM_PORTS-1:0] grant_v_q, grant_v_d;
  logic [IDX_W-1:0]     last_q, last_d;

  logic [IDX_W-1:0]     win_c;
  logic                 any_c;
  logic                 busy_c;
  logic                 last_beat_c;

  l2_rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .req       (bus.req),
    .last_idx  (last_q),
    .winner    (win_c),
    .any_valid (any_c)
  );

  assign busy_c      = (state_q == BURST);
  assign last_beat_c = busy_c && (cnt_q == '0);

  // Next-state: grant from IDLE, count accepted beats in BURST, release on last beat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_i_d = grant_i_q;
    grant_v_d = grant_v_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (any_c) begin
          state_d   = BURST;
          grant_i_d = win_c;
          grant_v_d = NUM_PORTS'(1) << win_c;
          cnt_d     = bus.req_len[win_c];
        end
      end
      BURST: begin
        if (bus.out_ready) begin
          if (cnt_q == '0) begin
            state_d   = IDLE;
            grant_v_d = '0;
            last_d    = grant_i_q;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_i_q <= '0;
      grant_v_q <= '0;
      last_q    <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_i_q <= grant_i_d;
      grant_v_q <= grant_v_d;
      last_q    <= last_d;
    end
  end

  assign bus.out_valid = busy_c;
  assign bus.busy      = busy_c;
  assign bus.out_last  = last_beat_c;
  assign bus.grant_v   = grant_v_q;
  // With a single port there is nothing to rotate; the index is constant.
  assign bus.grant_i   = (NUM_PORTS == 1) ? '0 : grant_i_q;
  assign bus.port_ack  = grant_v_q & {NUM_PORTS{busy_c & bus.out_ready}};

  // The granted port must keep requesting until its last beat is taken.
  req_held_a: assert property (@(posedge clk) disable iff (rst)
    busy_c |-> |(bus.req & grant_v_q))
    else $error("granted port dropped req mid-burst");

endmodule

// File: tb/tb_l2_burst_grant_sequencer.sv
module tb_l2_burst_grant_sequencer;

  logic clk = 1'b0;
  logic rst;

  l2_burst_grant_sequencer_if #(.NUM_PORTS(4), .LEN_W(4)) bus ();

  l2_burst_grant_sequencer #(.NUM_PORTS(4), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic        rdy;
    logic        eb;
    logic        el;
    logic [3:0]  egv;
    logic [1:0]  egi;
    logic        gi_chk;
    logic [3:0]  eack;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [15:0] ln,
                              input logic rd, input logic eb, input logic el,
                              input logic [3:0] egv, input logic [1:0] egi,
                              input logic [3:0] eack);
    vec_t v;
    v.rst = r; v.req = rq; v.len = ln; v.rdy = rd;
    v.eb = eb; v.el = el; v.egv = egv; v.egi = egi; v.gi_chk = eb; v.eack = eack;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [15:0] ln, input logic rd);
    rst           = r;
    bus.req       = rq;
    bus.req_len   = ln;
    bus.out_ready = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 4'b0000, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", 32'(bus.out_valid), 0);
    chk("reset.last",  32'(bus.out_last),  0);
    chk("reset.gv",    32'(bus.grant_v),   0);
    chk("reset.gi",    32'(bus.grant_i),   0);
    chk("reset.ack",   32'(bus.port_ack),  0);
    chk("reset.busy",  32'(bus.busy),      0);

    // Port 0, len 2: three beats, last on the third, idle after.
    vecs.push_back(mk(0, 4'b0001, 16'h0002, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0001, 16'h0002, 1, 1, 0, 4'b0001, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 16'h0002, 1, 1, 0, 4'b0001, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0001, 16'h0002, 1, 1, 1, 4'b0001, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 16'h0002, 1, 0, 0, 4'b0000, 0, 4'b0000));
    // All ports, len 0, from reset: 0,1,2,3,0 with an idle bubble between.
    vecs.push_back(mk(1, 4'b1111, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 1, 1, 1, 4'b0001, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 1, 1, 1, 4'b0010, 1, 4'b0010));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 1, 1, 1, 4'b0100, 2, 4'b0100));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 1, 1, 1, 4'b1000, 3, 4'b1000));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, 16'h0000, 1, 1, 1, 4'b0001, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    // Port 2, len 3, ready 1,0,0,1,1,0,1: four accepted beats.
    vecs.push_back(mk(0, 4'b0100, 16'h0300, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 16'h0300, 1, 1, 0, 4'b0100, 2, 4'b0100));
    vecs.push_back(mk(0, 4'b0100, 16'h0300, 0, 1, 0, 4'b0100, 2, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 16'h0300, 0, 1, 0, 4'b0100, 2, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 16'h0300, 1, 1, 0, 4'b0100, 2, 4'b0100));
    vecs.push_back(mk(0, 4'b0100, 16'h0300, 1, 1, 0, 4'b0100, 2, 4'b0100));
    vecs.push_back(mk(0, 4'b0100, 16'h0300, 0, 1, 1, 4'b0100, 2, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 16'h0300, 1, 1, 1, 4'b0100, 2, 4'b0100));
    vecs.push_back(mk(0, 4'b0000, 16'h0300, 1, 0, 0, 4'b0000, 0, 4'b0000));
    // Make port 3 the last grantee, then req=1001: 0 wins by wrap, 3 follows.
    vecs.push_back(mk(0, 4'b1000, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1000, 16'h0000, 1, 1, 1, 4'b1000, 3, 4'b1000));
    vecs.push_back(mk(0, 4'b1001, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1001, 16'h0000, 1, 1, 1, 4'b0001, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b1001, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b1001, 16'h0000, 1, 1, 1, 4'b1000, 3, 4'b1000));
    vecs.push_back(mk(0, 4'b0000, 16'h0000, 1, 0, 0, 4'b0000, 0, 4'b0000));
    // Port 1 burst (last grantee 1), then port 2 len 5 aborted by reset on beat 2;
    // afterwards req=0110 must go to port 1 because reset restored the scan start.
    vecs.push_back(mk(0, 4'b0010, 16'h0500, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0010, 16'h0500, 1, 1, 1, 4'b0010, 1, 4'b0010));
    vecs.push_back(mk(0, 4'b0100, 16'h0500, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs.push_back(mk(0, 4'b0100, 16'h0500, 1, 1, 0, 4'b0100, 2, 4'b0100));
    vecs.push_back(mk(1, 4'b0100, 16'h0500, 1, 1, 0, 4'b0100, 2, 4'b0100));
    vecs.push_back(mk(0, 4'b0110, 16'h0500, 1, 0, 0, 4'b0000, 0, 4'b0000));
    vecs[vecs.size()-1].gi_chk = 1'b1;
    vecs.push_back(mk(0, 4'b0110, 16'h0500, 1, 1, 1, 4'b0010, 1, 4'b0010));
    vecs.push_back(mk(0, 4'b0000, 16'h0500, 1, 0, 0, 4'b0000, 0, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].len, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d.valid", i), 32'(bus.out_valid), 32'(vecs[i].eb));
      chk($sformatf("v%0d.busy", i),  32'(bus.busy),      32'(vecs[i].eb));
      chk($sformatf("v%0d.last", i),  32'(bus.out_last),  32'(vecs[i].el));
      chk($sformatf("v%0d.gv", i),    32'(bus.grant_v),   32'(vecs[i].egv));
      chk($sformatf("v%0d.ack", i),   32'(bus.port_ack),  32'(vecs[i].eack));
      if (vecs[i].gi_chk)
        chk($sformatf("v%0d.gi", i), 32'(bus.grant_i), 32'(vecs[i].egi));
      step();
    end

    // Maximum length: exactly 16 beats, last only on the 16th, then idle.
    drive(1'b0, 4'b0001, 16'h000F, 1'b1);
    #1;
    chk("max.idle_busy", 32'(bus.busy), 0);
    step();
    for (int b = 1; b <= 16; b++) begin
      chk($sformatf("max.b%0d.busy", b), 32'(bus.busy),     1);
      chk($sformatf("max.b%0d.last", b), 32'(bus.out_last), (b == 16) ? 1 : 0);
      chk($sformatf("max.b%0d.ack", b),  32'(bus.port_ack), 32'h1);
      chk($sformatf("max.b%0d.gi", b),   32'(bus.grant_i),  0);
      step();
    end
    drive(1'b0, 4'b0000, 16'h000F, 1'b1);
    #1;
    chk("max.after_busy", 32'(bus.busy),     0);
    chk("max.after_last", 32'(bus.out_last), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
